phase_sequencer: RTL and testbench
==================================

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 SHALL have parameter MD_TIMEOUT, default 64: maximum cycles spent in MD_WAIT before a fault is raised.
REQ-002 SHALL have parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-003 SHALL have port clk_100M, input, 1: the only clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port run, input, 1: high permits new instruction sequences to start.
REQ-006 SHALL have port is_mem, input, 1: the decoded instruction needs a RAM phase.
REQ-007 SHALL have port is_muldiv, input, 1: the decoded instruction uses the multi-cycle mul/div unit.
REQ-008 SHALL have port md_done, input, 1: the mul/div unit has completed.
REQ-009 SHALL have port mem_ready, input, 1: the RAM access has completed.
REQ-010 SHALL have port en_fetch, output, 1: fetch strobe.
REQ-011 SHALL have ports en_dec, en_alu and en_reg, output, 1 each: decode, ALU and register-writeback strobes.
REQ-012 SHALL have ports md_start and en_ram, output, 1 each: mul/div start strobe and RAM strobe.
REQ-013 SHALL have port phase, output, 3: current state encoding.
REQ-014 SHALL have ports busy and md_fault, output, 1 each: sequence-in-progress flag and sticky mul/div timeout flag.
REQ-015 SHALL have port instr_cnt, output, CNT_W: count of retired instructions.

Function
REQ-016 SHALL implement states with these phase encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MD_WAIT=4, MEM=5, MEM_WAIT=6, WB=7.
REQ-017 SHALL derive all strobes as Moore decodes of the registered state, so they are glitch-free.
REQ-018 SHALL transition IDLE->FETCH on the edge where run=1, and remain in IDLE otherwise.
REQ-019 SHALL make FETCH, DECODE, EXEC, MEM and WB last exactly one cycle each.
REQ-020 SHALL assert en_fetch in FETCH, en_dec in DECODE, en_alu in EXEC, en_ram in MEM and en_reg in WB.
REQ-021 SHALL capture is_mem and is_muldiv into flags on the DECODE->EXEC edge; those inputs are ignored in all other states.
REQ-022 SHALL assert md_start in EXEC only when the captured muldiv flag is 1.
REQ-023 SHALL leave EXEC for MD_WAIT if the muldiv flag is set, else for MEM if the mem flag is set, else for WB.
REQ-024 SHALL hold MD_WAIT until md_done=1, then go to MEM if the mem flag is set, else to WB.
REQ-025 SHALL, when both flags are set, complete mul/div before the RAM phase.
REQ-026 SHALL always go MEM->MEM_WAIT; MEM_WAIT SHALL hold until mem_ready=1, then go to WB; mem_ready sampled in MEM is ignored.
REQ-027 SHALL increment instr_cnt by 1 in WB, wrapping modulo 2^CNT_W.
REQ-028 SHALL go WB->FETCH if run=1, else WB->IDLE; run deasserted mid-instruction never aborts the current instruction.
REQ-029 SHALL count cycles in MD_WAIT; if the count reaches MD_TIMEOUT with md_done=0, it SHALL set md_fault, suppress en_reg and instr_cnt for that instruction, and go to IDLE.
REQ-030 SHALL treat md_done=1 arriving in the same cycle the timeout is reached as completion, with no fault.
REQ-031 SHALL, while md_fault=1, hold the FSM in IDLE regardless of run; md_fault clears only on reset.
REQ-032 SHALL drive busy=1 in every state except IDLE.
REQ-033 SHALL give a minimum instruction period of 4 cycles (FETCH, DECODE, EXEC, WB), with back-to-back instructions having no IDLE gap.

Reset
REQ-034 SHALL, on rst_n=0, immediately force state=IDLE and phase=0, clear all strobes, busy, md_fault, both flags, the timeout counter and instr_cnt to 0, independent of clk_100M.
REQ-035 SHALL treat reset asserted mid-instruction as an abort, with no completion strobe emitted afterwards.

Structure
REQ-036 SHALL place the state encodings and the MD_TIMEOUT and CNT_W defaults in the shared CPU package.
REQ-037 SHALL implement the MD_WAIT timeout as one sub-module, seq_timeout_cnt (clear, enable, expired), clocked by clk_100M and reset by rst_n.

Verification
REQ-038 SHALL cover: run=1, is_mem=0, is_muldiv=0 for 3 instructions -> phase sequence 1,2,3,7 repeating, with en_fetch every 4 cycles and instr_cnt=3.
REQ-039 SHALL cover: is_mem=1, mem_ready raised 3 cycles after MEM -> phase 1,2,3,5,6,6,6,7 with en_ram for exactly 1 cycle.
REQ-040 SHALL cover: is_mem=1, is_muldiv=1, md_done after 5 cycles -> one md_start pulse, MD_WAIT before MEM, en_reg once.
REQ-041 SHALL cover: MD_TIMEOUT=8, md_done held 0 -> md_fault=1 after 8 MD_WAIT cycles, then IDLE, no en_reg, instr_cnt unchanged, and run ignored until reset.
REQ-042 SHALL cover: run dropped in DECODE -> the instruction completes through WB, then phase=0 and busy=0.
REQ-043 SHALL cover: rst_n pulsed low in MEM_WAIT, mid-cycle -> outputs clear asynchronously and no en_reg follows.

Source files
------------

// File: rtl/phase_sequencer_pkg.sv
// Shared CPU sequencing package: phase encodings, default sizing and the
// Moore strobe decode used by the phase sequencer.
package phase_sequencer_pkg;

    // Phase encodings are architectural: they appear directly on the phase port.
    typedef enum logic [2:0] {
        PH_IDLE     = 3'd0,
        PH_FETCH    = 3'd1,
        PH_DECODE   = 3'd2,
        PH_EXEC     = 3'd3,
        PH_MD_WAIT  = 3'd4,
        PH_MEM      = 3'd5,
        PH_MEM_WAIT = 3'd6,
        PH_WB       = 3'd7
    } phase_e;

    // Default maximum number of cycles spent waiting on the mul/div unit.
    localparam int unsigned MD_TIMEOUT_DEF = 64;
    // Default width of the retired-instruction counter.
    localparam int unsigned CNT_W_DEF      = 32;

    // One bit per sequencer output strobe plus the busy flag.
    typedef struct packed {
        logic fetch;
        logic dec;
        logic alu;
        logic md_start;
        logic ram;
        logic reg_wb;
        logic busy;
    } strobe_t;

    // Where the sequence goes once the compute part of an instruction is over.
    function automatic phase_e post_compute_phase(input logic mem_flag);
        return mem_flag ? PH_MEM : PH_WB;
    endfunction

    // Pure decode of the registered phase; md_start additionally needs the
    // captured muldiv flag, which is itself a register, so the result stays glitch-free.
    function automatic strobe_t decode_strobes(input phase_e ph, input logic md_flag);
        strobe_t s;
        s          = '0;
        s.busy     = (ph != PH_IDLE);
        s.fetch    = (ph == PH_FETCH);
        s.dec      = (ph == PH_DECODE);
        s.alu      = (ph == PH_EXEC);
        s.md_start = (ph == PH_EXEC) && md_flag;
        s.ram      = (ph == PH_MEM);
        s.reg_wb   = (ph == PH_WB);
        return s;
    endfunction

endpackage

// File: rtl/phase_sequencer_timeout.sv
// Cycle counter guarding the mul/div wait phase. It counts enabled cycles
// from zero after a clear and flags the LIMIT-th enabled cycle as expired.
module seq_timeout_cnt
    import phase_sequencer_pkg::*;
#(
    parameter int unsigned LIMIT = MD_TIMEOUT_DEF
) (
    input  logic clk_100M,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_limit;

    // The k-th enabled cycle after a clear sees cnt_q == k-1.
    assign at_limit  = (cnt_q == CW'(LIMIT - 1));
    assign expired_o = enable_i && at_limit;

    // Next count: clear wins, otherwise advance while enabled and not yet at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !at_limit) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register, cleared asynchronously by reset.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: steps each instruction through fetch, decode,
// execute, optional mul/div wait, optional RAM access and writeback.
//
// Handshake semantics: md_done and mem_ready are level "done" indications
// from the respective units. They are only sampled in MD_WAIT and MEM_WAIT;
// the cycle in which the sequencer sees them high is the completion cycle, and
// the sequencer leaves the wait phase on the following clock edge. Values
// presented in any other phase have no effect.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int unsigned MD_TIMEOUT = MD_TIMEOUT_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic             clk_100M,
    input  logic             rst_n,
    input  logic             run,
    input  logic             is_mem,
    input  logic             is_muldiv,
    input  logic             md_done,
    input  logic             mem_ready,
    output logic             en_fetch,
    output logic             en_dec,
    output logic             en_alu,
    output logic             en_reg,
    output logic             md_start,
    output logic             en_ram,
    output logic [2:0]       phase,
    output logic             busy,
    output logic             md_fault,
    output logic [CNT_W-1:0] instr_cnt
);

    phase_e           state_q, state_d;
    logic             mem_q, mem_d;
    logic             md_q, md_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             md_expired;
    logic             md_timeout_hit;
    strobe_t          strobe_s;

    // The timeout counter only runs in MD_WAIT and restarts from zero on every entry.
    seq_timeout_cnt #(
        .LIMIT (MD_TIMEOUT)
    ) u_md_timeout (
        .clk_100M  (clk_100M),
        .rst_n     (rst_n),
        .clear_i   (state_q != PH_MD_WAIT),
        .enable_i  (state_q == PH_MD_WAIT),
        .expired_o (md_expired)
    );

    // md_done in the expiry cycle counts as a normal completion, not a fault.
    assign md_timeout_hit = (state_q == PH_MD_WAIT) && md_expired && !md_done;

    // Next-state logic; a raised fault parks the sequencer in IDLE until reset.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PH_IDLE: begin
                if (run && !fault_q) begin
                    state_d = PH_FETCH;
                end
            end
            PH_FETCH:  state_d = PH_DECODE;
            PH_DECODE: state_d = PH_EXEC;
            PH_EXEC: begin
                // Mul/div always precedes the RAM phase when both are needed.
                if (md_q) begin
                    state_d = PH_MD_WAIT;
                end else begin
                    state_d = post_compute_phase(mem_q);
                end
            end
            PH_MD_WAIT: begin
                if (md_done) begin
                    state_d = post_compute_phase(mem_q);
                end else if (md_timeout_hit) begin
                    state_d = PH_IDLE;
                end
            end
            PH_MEM: state_d = PH_MEM_WAIT;
            PH_MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = PH_WB;
                end
            end
            PH_WB: begin
                // run only gates the start of the next instruction, never the current one.
                state_d = run ? PH_FETCH : PH_IDLE;
            end
            default: state_d = PH_IDLE;
        endcase
    end

    // Instruction flags, sticky fault and retired counter next values.
    always_comb begin
        mem_d   = mem_q;
        md_d    = md_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        if (state_q == PH_DECODE) begin
            mem_d = is_mem;
            md_d  = is_muldiv;
        end
        if (md_timeout_hit) begin
            fault_d = 1'b1;
        end
        if (state_q == PH_WB) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Phase register; reset forces IDLE immediately, aborting any instruction.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Captured instruction flags, fault flag and retired-instruction counter.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= 1'b0;
            md_q    <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            mem_q   <= mem_d;
            md_q    <= md_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore output decode of the registered phase.
    always_comb begin
        strobe_s = decode_strobes(state_q, md_q);
    end

    assign en_fetch  = strobe_s.fetch;
    assign en_dec    = strobe_s.dec;
    assign en_alu    = strobe_s.alu;
    assign md_start  = strobe_s.md_start;
    assign en_ram    = strobe_s.ram;
    assign en_reg    = strobe_s.reg_wb;
    assign busy      = strobe_s.busy;
    assign phase     = state_q;
    assign md_fault  = fault_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer with a shortened mul/div timeout.
module tb_phase_sequencer;

    logic        clk_100M;
    logic        rst_n;
    logic        run;
    logic        is_mem;
    logic        is_muldiv;
    logic        md_done;
    logic        mem_ready;
    logic        en_fetch;
    logic        en_dec;
    logic        en_alu;
    logic        en_reg;
    logic        md_start;
    logic        en_ram;
    logic [2:0]  phase;
    logic        busy;
    logic        md_fault;
    logic [31:0] instr_cnt;

    int total = 0;
    int bad   = 0;

    wire [6:0] strb = {en_fetch, en_dec, en_alu, md_start, en_ram, en_reg, busy};

    phase_sequencer #(
        .MD_TIMEOUT (8),
        .CNT_W      (32)
    ) dut (
        .clk_100M  (clk_100M),
        .rst_n     (rst_n),
        .run       (run),
        .is_mem    (is_mem),
        .is_muldiv (is_muldiv),
        .md_done   (md_done),
        .mem_ready (mem_ready),
        .en_fetch  (en_fetch),
        .en_dec    (en_dec),
        .en_alu    (en_alu),
        .en_reg    (en_reg),
        .md_start  (md_start),
        .en_ram    (en_ram),
        .phase     (phase),
        .busy      (busy),
        .md_fault  (md_fault),
        .instr_cnt (instr_cnt)
    );

    // Clock: 10 ns period.
    initial begin
        clk_100M = 1'b0;
        forever #5 clk_100M = ~clk_100M;
    end

    // Expected {fetch, dec, alu, md_start, ram, reg, busy} for each phase.
    function automatic logic [6:0] strobes_for(input int ph, input bit md);
        case (ph)
            1:       return 7'b1000001;
            2:       return 7'b0100001;
            3:       return md ? 7'b0011001 : 7'b0010001;
            4:       return 7'b0000001;
            5:       return 7'b0000101;
            6:       return 7'b0000001;
            7:       return 7'b0000011;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100M);
        #1;
    endtask

    // Advance one cycle, then check phase and the full strobe vector.
    task automatic step(input string tag, input int ph, input bit md);
        tick();
        chk({tag, " phase"}, 32'(phase), 32'(ph));
        chk({tag, " strobes"}, 32'(strb), 32'(strobes_for(ph, md)));
    endtask

    initial begin
        rst_n     = 1'b0;
        run       = 1'b0;
        is_mem    = 1'b0;
        is_muldiv = 1'b0;
        md_done   = 1'b0;
        mem_ready = 1'b0;

        // Reset state, before any clock edge.
        #3;
        chk("rst phase", 32'(phase), 32'd0);
        chk("rst strobes", 32'(strb), 32'd0);
        chk("rst fault", 32'(md_fault), 32'd0);
        chk("rst cnt", instr_cnt, 32'd0);
        tick();
        rst_n = 1'b1;
        step("idle hold", 0, 0);

        // Three plain instructions back to back: 1,2,3,7 repeating.
        run = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step("plain", 1, 0);
            if (n == 2) run = 1'b0;
            step("plain", 2, 0);
            step("plain", 3, 0);
            step("plain", 7, 0);
        end
        step("plain end", 0, 0);
        chk("plain cnt", instr_cnt, 32'd3);

        // Memory instruction, mem_ready three cycles after MEM.
        run    = 1'b1;
        is_mem = 1'b1;
        step("mem", 1, 0);
        run = 1'b0;
        step("mem", 2, 0);
        step("mem", 3, 0);
        is_mem = 1'b0;
        step("mem", 5, 0);
        step("mem", 6, 0);
        step("mem", 6, 0);
        step("mem", 6, 0);
        mem_ready = 1'b1;
        step("mem", 7, 0);
        mem_ready = 1'b0;
        step("mem end", 0, 0);
        chk("mem cnt", instr_cnt, 32'd4);

        // Mul/div plus memory: md_done on the 5th MD_WAIT cycle, mem_ready held from MEM.
        run       = 1'b1;
        is_mem    = 1'b1;
        is_muldiv = 1'b1;
        step("mdmem", 1, 0);
        run = 1'b0;
        step("mdmem", 2, 0);
        step("mdmem", 3, 1);
        is_mem    = 1'b0;
        is_muldiv = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step("mdmem wait", 4, 0);
            if (k == 5) md_done = 1'b1;
        end
        step("mdmem", 5, 0);
        md_done   = 1'b0;
        mem_ready = 1'b1;
        step("mdmem", 6, 0);
        step("mdmem", 7, 0);
        mem_ready = 1'b0;
        step("mdmem end", 0, 0);
        chk("mdmem cnt", instr_cnt, 32'd5);

        // run dropped in DECODE: instruction still completes.
        run = 1'b1;
        step("drop", 1, 0);
        step("drop", 2, 0);
        run = 1'b0;
        step("drop", 3, 0);
        step("drop", 7, 0);
        step("drop end", 0, 0);
        chk("drop cnt", instr_cnt, 32'd6);

        // Asynchronous reset in MEM_WAIT, mid-cycle.
        run    = 1'b1;
        is_mem = 1'b1;
        step("abort", 1, 0);
        run = 1'b0;
        step("abort", 2, 0);
        step("abort", 3, 0);
        step("abort", 5, 0);
        step("abort", 6, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort async phase", 32'(phase), 32'd0);
        chk("abort async strobes", 32'(strb), 32'd0);
        chk("abort async cnt", instr_cnt, 32'd0);
        is_mem    = 1'b0;
        mem_ready = 1'b1;
        step("abort held", 0, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) step("abort after", 0, 0);
        mem_ready = 1'b0;

        // One plain instruction after the abort.
        run = 1'b1;
        step("post", 1, 0);
        run = 1'b0;
        step("post", 2, 0);
        step("post", 3, 0);
        step("post", 7, 0);
        step("post end", 0, 0);
        chk("post cnt", instr_cnt, 32'd1);

        // md_done on the timeout cycle itself is a completion.
        run       = 1'b1;
        is_muldiv = 1'b1;
        step("edge", 1, 0);
        run = 1'b0;
        step("edge", 2, 0);
        step("edge", 3, 1);
        is_muldiv = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step("edge wait", 4, 0);
            if (k == 8) md_done = 1'b1;
        end
        step("edge", 7, 0);
        md_done = 1'b0;
        step("edge end", 0, 0);
        chk("edge fault", 32'(md_fault), 32'd0);
        chk("edge cnt", instr_cnt, 32'd2);

        // Timeout: md_done never arrives.
        run       = 1'b1;
        is_muldiv = 1'b1;
        step("tmo", 1, 0);
        step("tmo", 2, 0);
        step("tmo", 3, 1);
        is_muldiv = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step("tmo wait", 4, 0);
            chk("tmo fault early", 32'(md_fault), 32'd0);
        end
        step("tmo idle", 0, 0);
        chk("tmo fault", 32'(md_fault), 32'd1);
        chk("tmo cnt", instr_cnt, 32'd2);
        for (int k = 0; k < 4; k++) step("tmo run ignored", 0, 0);
        chk("tmo fault sticky", 32'(md_fault), 32'd1);

        // Reset clears the fault and the sequencer runs again.
        rst_n = 1'b0;
        #2;
        chk("clr fault", 32'(md_fault), 32'd0);
        tick();
        rst_n = 1'b1;
        step("restart", 1, 0);
        run = 1'b0;
        step("restart", 2, 0);
        step("restart", 3, 0);
        step("restart", 7, 0);
        step("restart end", 0, 0);
        chk("restart cnt", instr_cnt, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
